axil_cfg_sequencer: RTL and testbench

AXIL_CFG_SEQUENCER -- requirements
Module: axil_cfg_sequencer

---
 rtl/axil_seq_pkg.sv | 39 +++
 rtl/axil_seq_cmd_ram.sv | 25 ++
 rtl/axil_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axil_cfg_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_seq_pkg.sv
// Shared types for the AXI-Lite configuration sequencer: op codes, FSM states and the command record.
package axil_seq_pkg;

  localparam int unsigned CMD_ADDR_MAX = 64;
  localparam int unsigned CMD_DATA_MAX = 64;

  localparam logic [1:0] RESP_OKAY = 2'd0;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    WR        = 4'd2,
    WR_RESP   = 4'd3,
    RD        = 4'd4,
    RD_DATA   = 4'd5,
    POLL_WAIT = 4'd6,
    DONE      = 4'd7,
    ERR       = 4'd8
  } state_e;

  // Command record sized for the widest supported bus; callers use the low ADDR_W/DATA_W bits.
  typedef struct packed {
    op_e                     op;
    logic [CMD_ADDR_MAX-1:0] adr;
    logic [CMD_DATA_MAX-1:0] data;
  } cmd_t;

  function automatic logic is_idle(input state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/axil_seq_cmd_ram.sv
// Command table: one write port, one synchronous read port, no reset so contents survive reset.
module axil_seq_cmd_ram #(
  parameter int unsigned N_CMD = 16,
  parameter int unsigned W     = 66,
  parameter int unsigned AW    = $clog2(N_CMD)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [N_CMD];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_cfg_sequencer.sv
// Table-driven AXI-Lite master running WRITE/READ/POLL/END commands, one transaction at a time.
// Define AXIL_SEQ_CHECK_EN to compare READ data against the entry and count mismatches in mism_cnt.
module axil_cfg_sequencer
  import axil_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_CMD    = 16,
  parameter int unsigned POLL_GAP = 100,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cmd_we,
  input  logic [$clog2(N_CMD)-1:0] cmd_waddr,
  input  logic [1:0]               cmd_wop,
  input  logic [ADDR_W-1:0]        cmd_wadr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic [ADDR_W-1:0]        AWADDR,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [DATA_W-1:0]        WDATA,
  output logic [DATA_W/8-1:0]      WSTRB,
  output logic                     WVALID,
  input  logic                     WREADY,
  input  logic [1:0]               BRESP,
  input  logic                     BVALID,
  output logic                     BREADY,
  output logic [ADDR_W-1:0]        ARADDR,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [DATA_W-1:0]        RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RVALID,
  output logic                     RREADY,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_W-1:0]        last_rdata,
  output logic [15:0]              mism_cnt
);

  localparam int unsigned PC_W   = $clog2(N_CMD);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ENT_W  = 2 + ADDR_W + DATA_W;
  localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1) + 1;
  localparam int unsigned CNT_W  = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(N_CMD - 1);

  state_e              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [ADDR_W-1:0]   r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [DATA_W-1:0]   r_last_rdata;
  logic [DATA_W-1:0]   r_exp;
  logic                r_is_poll;
  logic [CNT_W-1:0]    r_poll_cnt;
  logic [GAP_W-1:0]    r_gap;

  logic [PC_W-1:0]     w_rd_addr;
  logic [ENT_W-1:0]    w_rd_q;
  logic                w_tbl_we;
  cmd_t                w_cmd;
  logic                w_unused_cmd_hi;

  // Table reads run one entry ahead so the next command is ready on the cycle FETCH is entered.
  assign w_rd_addr = is_idle(r_state) ? '0 : PC_W'(r_pc + PC_W'(1));
  assign w_tbl_we  = cmd_we && !r_busy;

  axil_seq_cmd_ram #(
    .N_CMD (N_CMD),
    .W     (ENT_W)
  ) u_cmd_ram (
    .i_clk   (clk),
    .i_we    (w_tbl_we),
    .i_waddr (cmd_waddr),
    .i_wdata ({cmd_wop, cmd_wadr, cmd_wdata}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_q)
  );

  always_comb begin
    w_cmd.op   = op_e'(w_rd_q[ENT_W-1 -: 2]);
    w_cmd.adr  = CMD_ADDR_MAX'(w_rd_q[DATA_W +: ADDR_W]);
    w_cmd.data = CMD_DATA_MAX'(w_rd_q[DATA_W-1:0]);
  end

  assign w_unused_cmd_hi = ^{w_cmd.adr, w_cmd.data};

`ifdef AXIL_SEQ_CHECK_EN
  logic [15:0] r_mism_cnt;
  assign mism_cnt = r_mism_cnt;
`else
  assign mism_cnt = 16'h0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_last_rdata <= '0;
      r_exp        <= '0;
      r_is_poll    <= 1'b0;
      r_poll_cnt   <= '0;
      r_gap        <= '0;
`ifdef AXIL_SEQ_CHECK_EN
      r_mism_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_pc    <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
`ifdef AXIL_SEQ_CHECK_EN
            r_mism_cnt <= '0;
`endif
          end
        end
        FETCH: begin
          r_exp <= w_cmd.data[DATA_W-1:0];
          case (w_cmd.op)
            OP_WRITE: begin
              r_awaddr  <= w_cmd.adr[ADDR_W-1:0];
              r_wdata   <= w_cmd.data[DATA_W-1:0];
              r_wstrb   <= '1;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR;
            end
            OP_READ, OP_POLL: begin
              r_araddr   <= w_cmd.adr[ADDR_W-1:0];
              r_arvalid  <= 1'b1;
              r_is_poll  <= (w_cmd.op == OP_POLL);
              r_poll_cnt <= '0;
              r_state    <= RD;
            end
            default: begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end
          endcase
        end
        WR: begin
          // AW and W complete independently; the response phase waits for both.
          if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
          if ((!r_awvalid || AWREADY) && (!r_wvalid || WREADY)) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            r_bready <= 1'b0;
            if (BRESP != RESP_OKAY) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ERR;
            end else if (r_pc == LAST_PC) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_pc    <= PC_W'(r_pc + PC_W'(1));
              r_state <= FETCH;
            end
          end
        end
        RD: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (RVALID) begin
            r_rready     <= 1'b0;
            r_last_rdata <= RDATA;
            if (RRESP != RESP_OKAY) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ERR;
            end else if (r_is_poll && (RDATA != r_exp)) begin
              if (r_poll_cnt == CNT_W'(POLL_MAX - 1)) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ERR;
              end else begin
                r_poll_cnt <= CNT_W'(r_poll_cnt + CNT_W'(1));
                if (POLL_GAP == 0) begin
                  r_arvalid <= 1'b1;
                  r_state   <= RD;
                end else begin
                  r_gap   <= GAP_W'(POLL_GAP - 1);
                  r_state <= POLL_WAIT;
                end
              end
            end else begin
`ifdef AXIL_SEQ_CHECK_EN
              if (!r_is_poll && (RDATA != r_exp) && (r_mism_cnt != 16'hFFFF))
                r_mism_cnt <= r_mism_cnt + 16'd1;
`endif
              if (r_pc == LAST_PC) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= DONE;
              end else begin
                r_pc    <= PC_W'(r_pc + PC_W'(1));
                r_state <= FETCH;
              end
            end
          end
        end
        POLL_WAIT: begin
          if (r_gap == '0) begin
            r_arvalid <= 1'b1;
            r_state   <= RD;
          end else begin
            r_gap <= GAP_W'(r_gap - GAP_W'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign AWADDR     = r_awaddr;
  assign AWVALID    = r_awvalid;
  assign WDATA      = r_wdata;
  assign WSTRB      = r_wstrb;
  assign WVALID     = r_wvalid;
  assign BREADY     = r_bready;
  assign ARADDR     = r_araddr;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign last_rdata = r_last_rdata;

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Scoreboard bench for axil_cfg_sequencer: directed command tables against a configurable AXI-Lite slave.
module tb_axil_cfg_sequencer;
  import axil_seq_pkg::*;

  localparam int unsigned GAP  = 100;
  localparam int unsigned PMAX = 256;
  localparam logic [63:0] NONE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_waddr = '0;
  logic [1:0]  cmd_wop = '0;
  logic [31:0] cmd_wadr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] AWADDR, WDATA, ARADDR, last_rdata;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, error;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;
  logic [15:0] mism_cnt;

  axil_cfg_sequencer #(
    .ADDR_W(32), .DATA_W(32), .N_CMD(16), .POLL_GAP(GAP), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_we(cmd_we), .cmd_waddr(cmd_waddr), .cmd_wop(cmd_wop), .cmd_wadr(cmd_wadr), .cmd_wdata(cmd_wdata),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy), .done(done), .error(error), .last_rdata(last_rdata), .mism_cnt(mism_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Scoreboard queues (expected traffic) and slave response queues.
  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_w_q[$];
  logic [63:0] exp_ar_q[$];
  logic [1:0]  bresp_q[$];
  logic [31:0] rdata_q[$];
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  int n_aw = 0, n_ar = 0, cyc = 0, poll_epoch = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: decides handshakes on the falling edge, updates its outputs just after the rising edge.
  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit got_aw = 0, got_w = 0, rd_pend = 0;
    int aw_c = 0, w_c = 0, ar_c = 0;
    forever begin
      @(negedge clk);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_b  = BVALID && BREADY;
      hs_ar = ARVALID && ARREADY;
      hs_r  = RVALID && RREADY;
      @(posedge clk);
      #1;
      if (reset) begin
        BVALID = 0; RVALID = 0; got_aw = 0; got_w = 0; rd_pend = 0;
      end else begin
        if (hs_aw) got_aw = 1;
        if (hs_w)  got_w = 1;
        if (hs_b)  BVALID = 0;
        if (hs_r)  RVALID = 0;
        if (hs_ar) rd_pend = 1;
        if (got_aw && got_w && !BVALID) begin
          BVALID = 1;
          if (bresp_q.size() > 0) BRESP = bresp_q.pop_front();
          else BRESP = 2'd0;
          got_aw = 0; got_w = 0;
        end
        if (rd_pend && !RVALID) begin
          RVALID = 1;
          RRESP = 2'd0;
          if (rdata_q.size() > 0) RDATA = rdata_q.pop_front();
          else RDATA = 32'd0;
          rd_pend = 0;
        end
      end
      AWREADY = AWVALID && (aw_c >= aw_delay);
      WREADY  = WVALID && (w_c >= w_delay);
      ARREADY = ARVALID && (ar_c >= ar_delay);
      aw_c = AWVALID ? aw_c + 1 : 0;
      w_c  = WVALID ? w_c + 1 : 0;
      ar_c = ARVALID ? ar_c + 1 : 0;
    end
  end

  // Monitor: pops expected traffic on every handshake and checks protocol ordering.
  initial begin
    logic [63:0] e;
    logic [31:0] w_first = '0;
    bit w_prev = 0, b_prev = 0;
    int last_ar_cyc = 0, last_epoch = 0, n_w = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (WVALID && !w_prev) w_first = WDATA;
      if (AWVALID && AWREADY) begin
        n_aw++;
        e = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : NONE;
        chk("awaddr", 64'(AWADDR), e);
      end
      if (WVALID && WREADY) begin
        n_w++;
        e = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : NONE;
        chk("wdata", 64'(WDATA), e);
        chk("wstrb", 64'(WSTRB), 64'hF);
        chk("wdata_stable", 64'(WDATA), 64'(w_first));
      end
      if (BREADY && !b_prev) begin
        chk("bready_before_hs", 64'({AWVALID, WVALID}), 64'd0);
        chk("bready_hs_count", 64'(n_aw), 64'(n_w));
      end
      if (ARVALID && ARREADY) begin
        n_ar++;
        e = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : NONE;
        chk("araddr", 64'(ARADDR), e);
        if (poll_epoch != 0 && poll_epoch == last_epoch)
          chk("poll_gap_ge_100", 64'((cyc - last_ar_cyc) >= int'(GAP)), 64'd1);
        last_epoch = poll_epoch;
        last_ar_cyc = cyc;
      end
      w_prev = WVALID;
      b_prev = BREADY;
    end
  end

  task automatic load(input int idx, input logic [1:0] op, input logic [31:0] adr, input logic [31:0] data);
    cmd_we = 1; cmd_waddr = 4'(idx); cmd_wop = op; cmd_wadr = adr; cmd_wdata = data;
    @(negedge clk);
    cmd_we = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_flag(input string name, input bit want_err, input int budget);
    int n = 0;
    while (!(want_err ? error : done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(want_err ? error : done), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_error"}, 64'(error), 0);
    chk({tag, "_valids"}, 64'({AWVALID, WVALID, ARVALID}), 0);
    chk({tag, "_readys"}, 64'({BREADY, RREADY}), 0);
    chk({tag, "_addrs"}, {AWADDR, ARADDR}, 0);
    chk({tag, "_wdata_strb"}, 64'({WDATA, WSTRB}), 0);
    chk({tag, "_last_rdata"}, 64'(last_rdata), 0);
    chk({tag, "_mism_cnt"}, 64'(mism_cnt), 0);
  endtask

  task automatic push_writes();
    exp_aw_q.push_back(64'h40); exp_w_q.push_back(64'h1);
    exp_aw_q.push_back(64'h44); exp_w_q.push_back(64'h3);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 0;

    // Two writes then END, always-ready slave; a table write while busy must be ignored.
    load(0, OP_WRITE, 32'h40, 32'h1);
    load(1, OP_WRITE, 32'h44, 32'h3);
    load(2, OP_END, 32'h0, 32'h0);
    push_writes();
    base = n_aw;
    pulse_start();
    chk("busy_after_start", 64'(busy), 1);
    load(2, OP_WRITE, 32'h99, 32'h9);
    wait_flag("t1_done", 0, 200);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_writes", 64'(n_aw - base), 2);

    // Slow AW/W ready: BREADY only after both handshakes, WDATA held.
    aw_delay = 3; w_delay = 7;
    push_writes();
    base = n_aw;
    pulse_start();
    wait_flag("t2_done", 0, 300);
    chk("t2_writes", 64'(n_aw - base), 2);
    aw_delay = 0; w_delay = 0;

    // Poll succeeding on the third read.
    load(0, OP_POLL, 32'h0, 32'h2);
    load(1, OP_END, 32'h0, 32'h0);
    rdata_q.push_back(0); rdata_q.push_back(0); rdata_q.push_back(2);
    repeat (3) exp_ar_q.push_back(64'h0);
    poll_epoch = 1;
    base = n_ar;
    pulse_start();
    wait_flag("t3_done", 0, 1000);
    chk("t3_reads", 64'(n_ar - base), 3);
    chk("t3_error", 64'(error), 0);
    chk("t3_last_rdata", 64'(last_rdata), 2);

    // Poll never matching: error after PMAX reads.
    repeat (PMAX) exp_ar_q.push_back(64'h0);
    poll_epoch = 2;
    base = n_ar;
    pulse_start();
    wait_flag("t3b_error", 1, PMAX * 110);
    repeat (5) @(negedge clk);
    chk("t3b_reads", 64'(n_ar - base), 64'(PMAX));
    chk("t3b_done", 64'(done), 0);
    chk("t3b_busy", 64'(busy), 0);
    poll_epoch = 0;

    // Second write gets SLVERR: stop with error, no further traffic, then restart from entry 0.
    load(0, OP_WRITE, 32'h40, 32'h1);
    load(1, OP_WRITE, 32'h44, 32'h3);
    load(2, OP_END, 32'h0, 32'h0);
    bresp_q.push_back(2'd0); bresp_q.push_back(2'd2);
    push_writes();
    base = n_aw;
    pulse_start();
    wait_flag("t4_error", 1, 200);
    repeat (30) @(negedge clk);
    chk("t4_writes", 64'(n_aw - base), 2);
    chk("t4_done", 64'(done), 0);
    chk("t4_error_held", 64'(error), 1);
    push_writes();
    pulse_start();
    chk("t4_error_cleared", 64'(error), 0);
    wait_flag("t4_restart_done", 0, 200);

    // READ 0x44 with entry data 3, slave returns 5.
    load(0, OP_READ, 32'h44, 32'h3);
    load(1, OP_END, 32'h0, 32'h0);
    rdata_q.push_back(32'h5);
    exp_ar_q.push_back(64'h44);
    pulse_start();
    wait_flag("t5_done", 0, 200);
    chk("t5_last_rdata", 64'(last_rdata), 5);
`ifdef AXIL_SEQ_CHECK_EN
    chk("t5_mism_cnt", 64'(mism_cnt), 1);
`else
    chk("t5_mism_cnt", 64'(mism_cnt), 0);
`endif

    // Reset while ARVALID is pending, then rerun the preserved table.
    ar_delay = 1000;
    pulse_start();
    base = 0;
    while (!ARVALID && base < 20) begin
      @(negedge clk);
      base++;
    end
    chk("t6_arvalid_seen", 64'(ARVALID), 1);
    reset = 1;
    @(negedge clk);
    check_all_zero("t6_reset");
    reset = 0;
    ar_delay = 0;
    rdata_q.push_back(32'h5);
    exp_ar_q.push_back(64'h44);
    pulse_start();
    wait_flag("t6_done", 0, 200);
    chk("t6_last_rdata", 64'(last_rdata), 5);
    chk("t6_busy", 64'(busy), 0);

    repeat (5) @(negedge clk);
    chk("pending_expected", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
